// File: rtl/bsg_iso_seq_pkg.sv
// bsg_iso_seq_pkg: shared state encoding and default timing constants for the isolation sequencer
//   BSG_ISO_SEQ_RETENTION_EN adds SAVE/RESTORE states and widens the state encoding to 4 bits
package bsg_iso_seq_pkg;
  localparam int settle_cycles_default = 4;
  localparam int timeout_cycles_default = 64;
`ifdef BSG_ISO_SEQ_RETENTION_EN
  localparam int state_w = 4;
`else
  localparam int state_w = 3;
`endif
  typedef enum logic [state_w-1:0] {
    S_OFF,
    S_PWR_UP,
    S_SETTLE_UP,
    S_ON,
    S_SETTLE_DN,
    S_PWR_DN,
    S_ERR
`ifdef BSG_ISO_SEQ_RETENTION_EN
    ,
    S_SAVE,
    S_RESTORE
`endif
  } iso_state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/bsg_iso_seq_timer.sv
// bsg_iso_seq_timer: reloadable down-counter shared by the settle and timeout intervals
//   clk_i/reset_i  clock and synchronous active-high reset
//   load_i, val_i  reload the counter with val_i
//   count_i        decrement toward zero (holds at zero)
//   zero_o         counter has reached zero
module bsg_iso_seq_timer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] val_i,
  input  logic               count_i,
  output logic               zero_o
);
  logic [width_p-1:0] cnt;
  always_ff @(posedge clk_i)
    cnt <= reset_i ? '0 : load_i ? val_i : (count_i && !zero_o) ? cnt - 1'b1 : cnt;
  assign zero_o = cnt == '0;
endmodule

// File: rtl/bsg_level_shift_iso_sequencer.sv
// bsg_level_shift_iso_sequencer: sequences power switch and isolation enable for a switchable domain
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_v_i/req_on_i/req_ready_o  power-transition request handshake (1 = on, 0 = off)
//   pwr_good_i               domain power-good, only observed in PWR_UP/PWR_DN
//   pwr_sw_en_o, iso_en_o    power-switch enable, isolation enable (drives sink v1_en_i)
//   done_v_o, err_o, state_o transition-complete pulse, sticky timeout error, debug state
//   BSG_ISO_SEQ_RETENTION_EN adds save_o, restore_o, ret_ack_i and SAVE/RESTORE states
module bsg_level_shift_iso_sequencer
  import bsg_iso_seq_pkg::*;
#(
  parameter int settle_cycles_p  = settle_cycles_default,
  parameter int timeout_cycles_p = timeout_cycles_default
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               req_v_i,
  input  logic               req_on_i,
  output logic               req_ready_o,
  input  logic               pwr_good_i,
  output logic               pwr_sw_en_o,
  output logic               iso_en_o,
  output logic               done_v_o,
  output logic               err_o,
  output logic [state_w-1:0] state_o
`ifdef BSG_ISO_SEQ_RETENTION_EN
  ,
  output logic               save_o,
  output logic               restore_o,
  input  logic               ret_ack_i
`endif
);
  localparam int cnt_w = $clog2(max_int(settle_cycles_p, timeout_cycles_p)) + 1;
`ifdef BSG_ISO_SEQ_RETENTION_EN
  localparam iso_state_e up_done_st = S_RESTORE;
  localparam iso_state_e dn_done_st = S_SAVE;
`else
  localparam iso_state_e up_done_st = S_ON;
  localparam iso_state_e dn_done_st = S_PWR_DN;
`endif
  iso_state_e state, next, cur;
  logic done, done_n, accept, zero, load;
  logic [cnt_w-1:0] val;
  assign accept = req_v_i && (state == S_OFF || state == S_ON || state == S_ERR);
  always_comb begin
    next = state;
    case (state)
      S_OFF:       next = accept && req_on_i ? S_PWR_UP : S_OFF;
      S_PWR_UP:    next = pwr_good_i ? S_SETTLE_UP : zero ? S_ERR : S_PWR_UP;
      S_SETTLE_UP: next = zero ? up_done_st : S_SETTLE_UP;
      S_ON:        next = accept && !req_on_i ? S_SETTLE_DN : S_ON;
      S_SETTLE_DN: next = zero ? dn_done_st : S_SETTLE_DN;
      S_PWR_DN:    next = !pwr_good_i ? S_OFF : zero ? S_ERR : S_PWR_DN;
      S_ERR:       next = accept && !req_on_i ? S_OFF : S_ERR;
`ifdef BSG_ISO_SEQ_RETENTION_EN
      S_SAVE:      next = ret_ack_i ? S_PWR_DN : zero ? S_ERR : S_SAVE;
      S_RESTORE:   next = ret_ack_i ? S_ON : zero ? S_ERR : S_RESTORE;
`endif
      default:     next = S_OFF;
    endcase
  end
  // done fires for a redundant request or on arrival in a stable ON/OFF state
  assign done_n = (accept && (req_on_i ? state == S_ON : state == S_OFF))
               || (next != state && (next == S_ON || next == S_OFF));
  // every state entry reloads the timer; settle states get the settle length, all others the timeout
  assign load = next != state;
  assign val  = (next == S_SETTLE_UP || next == S_SETTLE_DN) ? cnt_w'(settle_cycles_p - 1)
                                                             : cnt_w'(timeout_cycles_p - 1);
  bsg_iso_seq_timer #(.width_p(cnt_w)) timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .val_i   (val),
    .count_i (!load),
    .zero_o  (zero)
  );
  always_ff @(posedge clk_i) begin
    state <= reset_i ? S_OFF : next;
    done  <= !reset_i && done_n;
  end
  // outputs see OFF while reset is held so the switch and isolation drop without waiting
  assign cur         = reset_i ? S_OFF : state;
  assign req_ready_o = !reset_i && (state == S_OFF || state == S_ON || state == S_ERR);
  assign pwr_sw_en_o = !(cur == S_OFF || cur == S_PWR_DN || cur == S_ERR);
  assign iso_en_o    = cur == S_ON;
  assign err_o       = cur == S_ERR;
  assign done_v_o    = done && !reset_i;
  assign state_o     = cur;
`ifdef BSG_ISO_SEQ_RETENTION_EN
  assign save_o      = cur == S_SAVE;
  assign restore_o   = cur == S_RESTORE;
`endif
endmodule

// File: tb/tb_bsg_level_shift_iso_sequencer.sv
// tb_bsg_level_shift_iso_sequencer: directed and randomized self-check of the isolation sequencer
module tb_bsg_level_shift_iso_sequencer;
  import bsg_iso_seq_pkg::*;
  localparam int settle = 4;
  localparam int timeout = 64;
`ifdef BSG_ISO_SEQ_RETENTION_EN
  localparam int ret_extra = 1;
`else
  localparam int ret_extra = 0;
`endif
  logic clk = 0, reset = 1, req_v = 0, req_on = 0, good = 0;
  logic ready, sw, iso, done, err;
  logic [state_w-1:0] st;
`ifdef BSG_ISO_SEQ_RETENTION_EN
  logic save, restore, ack = 1;
`endif
  int checks = 0, fails = 0, cyc = 0, dcnt = 0;
  bit chk_en = 0, stuck = 0, stuck_val = 0;

  bsg_level_shift_iso_sequencer dut (
    .clk_i(clk), .reset_i(reset), .req_v_i(req_v), .req_on_i(req_on), .req_ready_o(ready),
    .pwr_good_i(good), .pwr_sw_en_o(sw), .iso_en_o(iso), .done_v_o(done), .err_o(err),
    .state_o(st)
`ifdef BSG_ISO_SEQ_RETENTION_EN
    , .save_o(save), .restore_o(restore), .ret_ack_i(ack)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) dcnt <= dcnt + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // reference model: phase plus cycles spent in that phase (counting up from 1)
  iso_state_e m_st = S_OFF, m_n, e_st;
  int m_el = 1;
  bit m_done = 0;
  logic m_acc;
  always_comb begin
    m_acc = req_v && (m_st == S_OFF || m_st == S_ON || m_st == S_ERR);
    m_n = m_st;
    case (m_st)
      S_OFF:       if (m_acc && req_on) m_n = S_PWR_UP;
      S_PWR_UP:    m_n = good ? S_SETTLE_UP : (m_el >= timeout ? S_ERR : m_st);
`ifdef BSG_ISO_SEQ_RETENTION_EN
      S_SETTLE_UP: if (m_el >= settle) m_n = S_RESTORE;
      S_SETTLE_DN: if (m_el >= settle) m_n = S_SAVE;
      S_SAVE:      m_n = ack ? S_PWR_DN : (m_el >= timeout ? S_ERR : m_st);
      S_RESTORE:   m_n = ack ? S_ON : (m_el >= timeout ? S_ERR : m_st);
`else
      S_SETTLE_UP: if (m_el >= settle) m_n = S_ON;
      S_SETTLE_DN: if (m_el >= settle) m_n = S_PWR_DN;
`endif
      S_ON:        if (m_acc && !req_on) m_n = S_SETTLE_DN;
      S_PWR_DN:    m_n = !good ? S_OFF : (m_el >= timeout ? S_ERR : m_st);
      S_ERR:       if (m_acc && !req_on) m_n = S_OFF;
      default:     m_n = S_OFF;
    endcase
  end
  always @(posedge clk) begin
    m_st   <= reset ? S_OFF : m_n;
    m_el   <= (reset || m_n != m_st) ? 1 : m_el + 1;
    m_done <= !reset && (m_n == S_ON || m_n == S_OFF) && (m_n != m_st || m_acc);
  end
  assign e_st = reset ? S_OFF : m_st;

  always @(negedge clk) if (chk_en) begin
    chk("ready", 32'(ready), 32'(!reset && (m_st == S_OFF || m_st == S_ON || m_st == S_ERR)));
    chk("pwr_sw_en", 32'(sw), 32'(!(e_st == S_OFF || e_st == S_PWR_DN || e_st == S_ERR)));
    chk("iso_en", 32'(iso), 32'(e_st == S_ON));
    chk("done_v", 32'(done), 32'(m_done && !reset));
    chk("err", 32'(err), 32'(e_st == S_ERR));
    chk("state", 32'(st), 32'(e_st));
`ifdef BSG_ISO_SEQ_RETENTION_EN
    chk("save", 32'(save), 32'(e_st == S_SAVE));
    chk("restore", 32'(restore), 32'(e_st == S_RESTORE));
`endif
  end

  initial begin
    int t0, d0, n;
    tick(); tick();
    chk_en = 1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_state", 32'(st), 32'(S_OFF));
    chk("rst_sw", 32'(sw), 0);
    reset = 0; tick();
    chk("ready_after_rst", 32'(ready), 1);
    // power up with good arriving 3 cycles after acceptance
    d0 = dcnt;
    req_v = 1; req_on = 1; tick(); req_v = 0; t0 = cyc;
    chk("up_sw", 32'(sw), 1);
    chk("up_iso", 32'(iso), 0);
    tick(); tick(); good = 1;
    for (int i = 0; i < 40 && iso !== 1'b1; i++) tick();
    chk("on_latency", 32'(cyc - t0 + 1), 32'(8 + ret_extra));
    chk("on_done_count", 32'(dcnt - d0), 1);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    // redundant on-request in ON
    req_v = 1; req_on = 1; tick(); req_v = 0;
    chk("redundant_on_done", 32'(done), 1);
    chk("redundant_on_iso", 32'(iso), 1);
    chk("redundant_on_state", 32'(st), 32'(S_ON));
    // power down
    req_v = 1; req_on = 0; tick(); req_v = 0;
    chk("dn_iso_next", 32'(iso), 0);
    chk("dn_sw_still_on", 32'(sw), 1);
    n = 0;
    for (int i = 0; i < 20 && sw === 1'b1; i++) begin tick(); n++; end
    chk("dn_sw_delay", 32'(n), 32'(4 + ret_extra));
    chk("dn_state", 32'(st), 32'(S_PWR_DN));
    good = 0; tick();
    chk("off_state", 32'(st), 32'(S_OFF));
    chk("off_done", 32'(done), 1);
    // redundant off-request and a good glitch in OFF
    tick();
    req_v = 1; req_on = 0; tick(); req_v = 0;
    chk("redundant_off_done", 32'(done), 1);
    chk("redundant_off_sw", 32'(sw), 0);
    good = 1; tick(); good = 0; tick();
    chk("glitch_off_state", 32'(st), 32'(S_OFF));
    // power good never arrives
    req_v = 1; req_on = 1; tick(); req_v = 0;
    n = 1;
    for (int i = 0; i < 200 && err !== 1'b1; i++) begin tick(); n++; end
    chk("pwr_up_cycles", 32'(n - 1), 64);
    chk("err_iso", 32'(iso), 0);
    chk("err_sw", 32'(sw), 0);
    req_v = 1; req_on = 1; tick();
    chk("err_on_ignored", 32'(err), 1);
    chk("err_on_no_done", 32'(done), 0);
    req_on = 0; tick(); req_v = 0;
    chk("err_exit_err", 32'(err), 0);
    chk("err_exit_state", 32'(st), 32'(S_OFF));
    chk("err_exit_done", 32'(done), 1);
    // reset during SETTLE_UP, requests ignored while settling
    req_v = 1; req_on = 1; tick(); req_v = 0; good = 1; tick();
    chk("settle_state", 32'(st), 32'(S_SETTLE_UP));
    req_v = 1; req_on = 0;
    chk("settle_not_ready", 32'(ready), 0);
    tick(); req_v = 0;
    chk("settle_req_ignored", 32'(st), 32'(S_SETTLE_UP));
    reset = 1; tick();
    chk("mid_rst_sw", 32'(sw), 0);
    chk("mid_rst_iso", 32'(iso), 0);
    chk("mid_rst_state", 32'(st), 32'(S_OFF));
    reset = 0; good = 0; tick();
    chk("mid_rst_ready", 32'(ready), 1);
`ifdef BSG_ISO_SEQ_RETENTION_EN
    good = 1; req_v = 1; req_on = 1; tick(); req_v = 0;
    for (int i = 0; i < 40 && iso !== 1'b1; i++) tick();
    chk("ret_on", 32'(iso), 1);
    ack = 0; req_v = 1; req_on = 0; tick(); req_v = 0;
    for (int i = 0; i < 20 && save !== 1'b1; i++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("save_held", 32'(save), 1);
      chk("save_sw_on", 32'(sw), 1);
      tick();
    end
    ack = 1; tick(); ack = 0;
    chk("save_done_sw", 32'(sw), 0);
    chk("save_released", 32'(save), 0);
    good = 0; tick();
    req_v = 1; req_on = 1; good = 1; tick(); req_v = 0;
    for (int i = 0; i < 20 && restore !== 1'b1; i++) tick();
    chk("restore_seen", 32'(restore), 1);
    chk("restore_before_iso", 32'(iso), 0);
    ack = 1; tick();
    chk("restore_then_iso", 32'(iso), 1);
`endif
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) begin
        stuck = $urandom_range(0, 3) == 0;
        stuck_val = 1'($urandom_range(0, 1));
      end
      req_v  = $urandom_range(0, 3) == 0;
      req_on = 1'($urandom_range(0, 1));
      good   = stuck ? stuck_val : ($urandom_range(0, 15) == 0 ? !sw : sw);
      reset  = $urandom_range(0, 299) == 0;
`ifdef BSG_ISO_SEQ_RETENTION_EN
      ack    = $urandom_range(0, 3) == 0;
`endif
      tick();
    end
    reset = 0; req_v = 0; tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/bsg_level_shift_iso_sequencer.md
BSG_LEVEL_SHIFT_ISO_SEQUENCER -- requirements
Module: bsg_level_shift_iso_sequencer

Interface
REQ-001 The block SHALL have parameter settle_cycles_p, default 4: cycles to hold between isolation and power-switch edges (range 1..255).
REQ-002 The block SHALL have parameter timeout_cycles_p, default 64: maximum cycles to wait for pwr_good_i to follow pwr_sw_en_o (range 1..1023).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the only clock.
REQ-004 The block SHALL have port reset_i, input, 1 bit: reset, synchronous to clk_i and active-high.
REQ-005 The block SHALL have port req_v_i, input, 1 bit: power-transition request valid.
REQ-006 The block SHALL have port req_on_i, input, 1 bit: requested domain state (1 = on, 0 = off).
REQ-007 The block SHALL have port req_ready_o, output, 1 bit: request accepted when req_v_i && req_ready_o.
REQ-008 The block SHALL have port pwr_good_i, input, 1 bit: the domain power-good indication.
REQ-009 The block SHALL have port pwr_sw_en_o, output, 1 bit: power-switch enable.
REQ-010 The block SHALL have port iso_en_o, output, 1 bit: drives the sink's v1_en_i (1 = pass data, 0 = clamp to 0).
REQ-011 The block SHALL have port done_v_o, output, 1 bit: one-cycle pulse when a transition completes.
REQ-012 The block SHALL have port err_o, output, 1 bit: sticky timeout error.
REQ-013 The block SHALL have port state_o, output, 3 bits: current state encoding, for debug.

Function
REQ-014 States SHALL be OFF, PWR_UP, SETTLE_UP, ON, SETTLE_DN, PWR_DN and ERR.
REQ-015 req_ready_o SHALL be 1 only in OFF, ON and ERR.
REQ-016 In OFF, an accepted request with req_on_i=1 SHALL move to PWR_UP and set pwr_sw_en_o=1 on the next cycle.
REQ-017 In OFF, an accepted request with req_on_i=0 SHALL cause no state change and SHALL pulse done_v_o on the next cycle.
REQ-018 In PWR_UP, the first cycle with pwr_good_i=1 SHALL move to SETTLE_UP; if timeout_cycles_p cycles elapse without it, the block SHALL move to ERR.
REQ-019 SETTLE_UP SHALL last exactly settle_cycles_p cycles, then enter ON with iso_en_o=1 and a one-cycle done_v_o pulse.
REQ-020 In ON, an accepted request with req_on_i=0 SHALL clear iso_en_o on the next cycle and enter SETTLE_DN.
REQ-021 In ON, an accepted request with req_on_i=1 SHALL only pulse done_v_o.
REQ-022 SETTLE_DN SHALL last exactly settle_cycles_p cycles, then enter PWR_DN with pwr_sw_en_o=0.
REQ-023 In PWR_DN, the first cycle with pwr_good_i=0 SHALL enter OFF and pulse done_v_o; a timeout SHALL enter ERR.
REQ-024 iso_en_o SHALL be 1 only in ON, so it is never 1 while pwr_sw_en_o=0 or pwr_good_i is unconfirmed.
REQ-025 In ERR, the outputs SHALL be pwr_sw_en_o=0, iso_en_o=0 and err_o=1.
REQ-026 In ERR, only an accepted request with req_on_i=0 SHALL exit; it SHALL go to OFF, clear err_o and pulse done_v_o.
REQ-027 A single down-counter SHALL serve both settle and timeout; it SHALL be reloaded on every state entry, with width $clog2 of the larger parameter plus 1.
REQ-028 pwr_good_i glitches outside PWR_UP and PWR_DN SHALL be ignored.

Reset
REQ-029 While reset_i=1, the state SHALL be OFF and the outputs SHALL be pwr_sw_en_o=0, iso_en_o=0, done_v_o=0, err_o=0, req_ready_o=0, state_o=OFF encoding.
REQ-030 A reset asserted mid-transition SHALL drop pwr_sw_en_o and iso_en_o on the next clock edge, with no settle delay.
REQ-031 req_ready_o SHALL be 1 from the first cycle after reset_i deasserts.

Configuration
REQ-032 When macro BSG_ISO_SEQ_RETENTION_EN is defined, the block SHALL add ports save_o (output, 1 bit), restore_o (output, 1 bit) and ret_ack_i (input, 1 bit), and states SAVE and RESTORE.
REQ-033 With BSG_ISO_SEQ_RETENTION_EN defined, SAVE SHALL sit between SETTLE_DN and PWR_DN: it asserts save_o until ret_ack_i=1, then enters PWR_DN.
REQ-034 With BSG_ISO_SEQ_RETENTION_EN defined, RESTORE SHALL sit between SETTLE_UP and ON: it asserts restore_o until ret_ack_i=1, then enters ON.
REQ-035 With BSG_ISO_SEQ_RETENTION_EN defined, SAVE and RESTORE SHALL use the same timeout to ERR as PWR_UP and PWR_DN.
REQ-036 Without BSG_ISO_SEQ_RETENTION_EN, those ports and states SHALL be absent and state_o SHALL remain 3 bits.

Structure
REQ-037 The state enum and its encodings SHALL live in the shared package bsg_iso_seq_pkg.
REQ-038 The default settle and timeout constants SHALL also live in bsg_iso_seq_pkg.
REQ-039 The counter SHALL be one sub-module, bsg_iso_seq_timer, with load, count and zero_o.
REQ-040 The block SHALL instantiate no level-shift cells; iso_en_o connects externally to the sink's v1_en_i.

Verification
REQ-041 The bench SHALL cover: reset, then on-request, pwr_good_i rising 3 cycles later -> iso_en_o=1 exactly 3+4+1 cycles after acceptance, one done_v_o pulse.
REQ-042 The bench SHALL cover: in ON, off-request -> iso_en_o=0 next cycle, pwr_sw_en_o=0 4 cycles later, pwr_good_i falls -> OFF and done_v_o.
REQ-043 The bench SHALL cover: on-request with pwr_good_i stuck at 0 -> ERR after 64 cycles, err_o=1, iso_en_o=0; then off-request -> OFF, err_o=0.
REQ-044 The bench SHALL cover: reset_i pulsed in SETTLE_UP -> pwr_sw_en_o=0 next cycle; req_v_i during SETTLE_* sees req_ready_o=0 and no state effect.
REQ-045 The bench SHALL cover: a redundant off-request in OFF and a redundant on-request in ON -> done_v_o only, with outputs unchanged.
REQ-046 The bench SHALL cover, with BSG_ISO_SEQ_RETENTION_EN defined: off-request -> save_o held until ret_ack_i arrives 5 cycles later, then pwr_sw_en_o=0; on-request -> restore_o precedes iso_en_o=1.
